// File: rtl/mse_pkg.sv
// Shared widths and FSM state type for the MSE monitor.
package mse_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIFF_W = 17;
  localparam int unsigned SQ_W   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSkip,
    StAccum,
    StDrain,
    StDone
  } state_e;
endpackage

// File: rtl/err_sq_stage.sv
// Registered difference and square stages, each with its own valid bit.
module err_sq_stage
  import mse_pkg::*;
(
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] y_approx,
  input  logic signed [DATA_W-1:0] y_exact,
  output logic [SQ_W-1:0]          sq,
  output logic [DATA_W-1:0]        abs_diff,
  output logic                     sq_valid
);

  logic signed [DIFF_W-1:0] diff_q;
  logic                     diff_valid_q;
  logic [DATA_W-1:0]        mag;
  logic [SQ_W-1:0]          sq_d;

  // |diff| never exceeds 65535, so the 16-bit magnitude squared is exact in 32 bits.
  always_comb begin
    mag  = diff_q[DIFF_W-1] ? DATA_W'(-diff_q) : DATA_W'(diff_q);
    sq_d = SQ_W'(mag) * SQ_W'(mag);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
      sq           <= '0;
      abs_diff     <= '0;
      sq_valid     <= 1'b0;
    end else begin
      diff_valid_q <= in_valid;
      if (in_valid) begin
        diff_q <= {y_approx[DATA_W-1], y_approx} - {y_exact[DATA_W-1], y_exact};
      end
      sq_valid <= diff_valid_q;
      if (diff_valid_q) begin
        sq       <= sq_d;
        abs_diff <= mag;
      end
    end
  end

endmodule

// File: rtl/mse_monitor.sv
// Measures mean squared error and peak absolute error between two filter outputs
// over a window of 2^N_LOG2 samples, after discarding SKIP pipeline-fill samples.
module mse_monitor
  import mse_pkg::*;
#(
  parameter int unsigned N_LOG2 = 8,
  parameter int unsigned SKIP   = 9
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] y_approx,
  input  logic signed [DATA_W-1:0] y_exact,
  output logic                     busy,
  output logic [31:0]              mse,
  output logic [DATA_W-1:0]        max_abs_err,
  output logic                     mse_valid
);

  localparam int unsigned N     = 1 << N_LOG2;
  localparam int unsigned AccW  = SQ_W + N_LOG2;
  localparam int unsigned SkipW = $clog2(SKIP + 1);
  localparam int unsigned CntW  = (N_LOG2 + 1 > SkipW) ? N_LOG2 + 1 : SkipW;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AccW-1:0]     acc_q;
  logic [DATA_W-1:0]   max_q;
  logic                commit_q;
  logic                honour;
  logic                pipe_in;
  logic [SQ_W-1:0]     sq;
  logic [DATA_W-1:0]   abs_diff;
  logic                sq_valid;

  assign honour  = start && (state_q == StIdle || state_q == StDone);
  assign pipe_in = in_valid && (state_q == StAccum);
  assign busy    = (state_q == StSkip) || (state_q == StAccum) || (state_q == StDrain);

  err_sq_stage u_err_sq_stage (
    .clk      (clk),
    .rstN     (rstN),
    .in_valid (pipe_in),
    .y_approx (y_approx),
    .y_exact  (y_exact),
    .sq       (sq),
    .abs_diff (abs_diff),
    .sq_valid (sq_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cnt_d   = '0;
          state_d = (SKIP == 0) ? StAccum : StSkip;
        end
      end
      StSkip: begin
        if (in_valid) begin
          if (cnt_q == CntW'(SKIP - 1)) begin
            cnt_d   = '0;
            state_d = StAccum;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StAccum: begin
        if (in_valid) begin
          if (cnt_q == CntW'(N - 1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        // Counter is reused to time the two drain cycles.
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last square lands in acc on the edge that leaves DRAIN, so results are
  // captured one edge later via commit_q.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_q       <= '0;
      max_q       <= '0;
      commit_q    <= 1'b0;
      mse         <= '0;
      max_abs_err <= '0;
      mse_valid   <= 1'b0;
    end else if (honour) begin
      acc_q     <= '0;
      max_q     <= '0;
      commit_q  <= 1'b0;
      mse_valid <= 1'b0;
    end else begin
      if (sq_valid) begin
        acc_q <= acc_q + AccW'(sq);
        if (abs_diff > max_q) begin
          max_q <= abs_diff;
        end
      end
      commit_q <= (state_q == StDrain) && (cnt_q == CntW'(1));
      if (commit_q) begin
        mse         <= 32'(acc_q >> N_LOG2);
        max_abs_err <= max_q;
        mse_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mse_monitor.sv
// Randomized self-checking bench for mse_monitor against a window-level reference model.
module tb_mse_monitor;
  localparam int N_LOG2 = 8;
  localparam int SKIP   = 9;
  localparam int N      = 1 << N_LOG2;

  logic               clk = 1'b0;
  logic               rstN;
  logic               start;
  logic               in_valid;
  logic signed [15:0] y_approx;
  logic signed [15:0] y_exact;
  logic               busy;
  logic [31:0]        mse;
  logic [15:0]        max_abs_err;
  logic               mse_valid;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  mse_monitor #(.N_LOG2(N_LOG2), .SKIP(SKIP)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .in_valid    (in_valid),
    .y_approx    (y_approx),
    .y_exact     (y_exact),
    .busy        (busy),
    .mse         (mse),
    .max_abs_err (max_abs_err),
    .mse_valid   (mse_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Modes: 0 equal, 1 +3 (+1000 in skip), 2 alternating +4/-5, 3 full-scale,
  // 4 constant 2, 5 random errors.
  task automatic run_window(input int mode, input bit toggle, input bit mid_start,
                            input string name);
    int          accepted, counted, k, e, ye, mx, c_last, rise;
    longint      sum;
    bit          vld, fired, busy_bad, hold_bad;
    logic [31:0] exp_mse;
    accepted = 0; counted = 0; k = 0; mx = 0; c_last = 0; sum = 0; fired = 0;
    @(posedge clk); #1;
    // A valid sample in the start cycle must not be accepted.
    start = 1'b1; in_valid = 1'b1; y_exact = 16'sd0; y_approx = 16'sd20000;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || mse_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s start_ack: busy=%b mse_valid=%b, required busy=1 mse_valid=0",
               name, busy, mse_valid);
    end
    while (counted < N) begin
      if (toggle) vld = (k % 2 == 0);
      else if (mode == 5) vld = ($urandom_range(0, 3) != 0);
      else vld = 1'b1;
      case (mode)
        0: e = 0;
        1: e = (accepted < SKIP) ? 1000 : 3;
        2: e = (counted % 2 == 0) ? 4 : -5;
        3: e = 65535;
        4: e = 2;
        default: e = int'($urandom_range(0, 4000)) - 2000;
      endcase
      if (mode == 3) ye = -32768;
      else ye = int'($urandom_range(0, 60000)) - 30000;
      y_exact  = 16'(ye);
      y_approx = 16'(ye + e);
      in_valid = vld;
      start    = 1'b0;
      if (mid_start && !fired && counted == 100) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (vld) begin
        if (accepted >= SKIP) begin
          sum += longint'(e) * longint'(e);
          if ((e < 0 ? -e : e) > mx) mx = (e < 0 ? -e : e);
          counted++;
          if (counted == N) c_last = cyc;
        end
        accepted++;
      end
      k++;
      @(posedge clk); #1;
    end
    start    = 1'b0;
    exp_mse  = 32'(sum >> N_LOG2);
    rise     = -1;
    busy_bad = 1'b0;
    for (int i = 0; i < 16 && rise < 0; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy !== 1'(cyc <= c_last + 2)) busy_bad = 1'b1;
      if (mse_valid === 1'b1) rise = cyc;
    end
    checks++;
    if (rise != c_last + 4) begin
      errors++;
      $display("FAIL %s latency: mse_valid rose at cycle %0d, required %0d", name, rise,
               c_last + 4);
    end
    checks++;
    if (mse !== exp_mse) begin
      errors++;
      $display("FAIL %s mse: got %0d, required %0d", name, mse, exp_mse);
    end
    checks++;
    if (max_abs_err !== 16'(mx)) begin
      errors++;
      $display("FAIL %s max_abs_err: got %0d, required %0d", name, max_abs_err, mx);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s busy_drain: busy profile wrong, required high through cycle %0d",
               name, c_last + 2);
    end
    hold_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      y_approx = 16'($urandom);
      @(negedge clk);
      if (mse_valid !== 1'b1 || mse !== exp_mse || max_abs_err !== 16'(mx)) hold_bad = 1'b1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL %s done_hold: got mse=%0d valid=%b, required mse=%0d valid=1", name, mse,
               mse_valid, exp_mse);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; in_valid = 1'b0; y_approx = '0; y_exact = '0;
    #12;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset busy: got %b, required 0", busy);
    end
    checks++;
    if (mse_valid !== 1'b0) begin
      errors++; $display("FAIL reset mse_valid: got %b, required 0", mse_valid);
    end
    checks++;
    if (mse !== 32'd0) begin
      errors++; $display("FAIL reset mse: got %0d, required 0", mse);
    end
    checks++;
    if (max_abs_err !== 16'd0) begin
      errors++; $display("FAIL reset max_abs_err: got %0d, required 0", max_abs_err);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
  endtask

  task automatic test_equal();          run_window(0, 1'b0, 1'b0, "equal");        endtask
  task automatic test_skip_excluded();  run_window(1, 1'b0, 1'b0, "skip_excl");    endtask
  task automatic test_alternating();    run_window(2, 1'b0, 1'b0, "alternating");  endtask
  task automatic test_full_scale();     run_window(3, 1'b0, 1'b0, "full_scale");   endtask
  task automatic test_gaps_busy_start(); run_window(4, 1'b1, 1'b1, "gaps_start");  endtask
  task automatic test_random();         run_window(5, 1'b0, 1'b0, "random");       endtask

  task automatic test_reset_mid_accum();
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < SKIP + 50; i++) begin
      in_valid = 1'b1;
      y_exact  = 16'(int'($urandom_range(0, 60000)) - 30000);
      y_approx = y_exact + 16'sd7;
      @(posedge clk); #1;
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midreset busy: got %b, required 0", busy);
    end
    checks++;
    if (mse_valid !== 1'b0) begin
      errors++; $display("FAIL midreset mse_valid: got %b, required 0", mse_valid);
    end
    checks++;
    if (mse !== 32'd0) begin
      errors++; $display("FAIL midreset mse: got %0d, required 0", mse);
    end
    checks++;
    if (max_abs_err !== 16'd0) begin
      errors++; $display("FAIL midreset max_abs_err: got %0d, required 0", max_abs_err);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    run_window(1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_equal();
    test_skip_excluded();
    test_alternating();
    test_full_scale();
    test_gaps_busy_start();
    test_random();
    test_reset_mid_accum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
